// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: run-time configuration sequencer for a CIC decimator.
// Handles decimation-factor change requests:
//   - holds the filter in reset for FlushCycles cycles;
//   - applies the new factor on flush entry;
//   - discards DiscardNum filter outputs before passing valid data on.
// Optional build macro CIC_DECIM_CTRL_STATS_EN adds DropCnt_o. It is a
// saturating count of DataNd_i strobes blocked while in FLUSH.
//
// state  | meaning
// -------+------------------------------------------------------------
// RUN    | normal operation, samples and outputs pass through
// FLUSH  | filter held in reset, counting down the flush interval
// SETTLE | filter running, transient outputs being discarded
module cic_decim_ctrl #(
  parameter int N            = 2,
  parameter int FlushCycles  = 8,
  parameter int DiscardNum   = 2 * N,
  parameter int DefaultDecim = 1
) (
  input  logic       Clk_i,
  input  logic       Rst_i,
  input  logic [2:0] CfgDecim_i,
  input  logic       CfgWr_i,
  output logic       CfgBusy_o,
  output logic       CfgErr_o,
  input  logic       DataNd_i,
  output logic       FiltNd_o,
  output logic       FiltRst_o,
  output logic [2:0] DecimFactor_o,
  input  logic       FiltValid_i,
  output logic       DataValid_o,
`ifdef CIC_DECIM_CTRL_STATS_EN
  output logic [1:0] State_o,
  output logic [15:0] DropCnt_o
`else
  output logic [1:0] State_o
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FLUSH  = 2'b01,
    SETTLE = 2'b10
  } state_t;

  localparam logic [7:0] FLUSH_LOAD   = 8'(FlushCycles);
  localparam logic [7:0] DISCARD_LOAD = 8'(DiscardNum);
  localparam logic [2:0] DECIM_RESET  = 3'(DefaultDecim);

  state_t     state;
  logic [7:0] flush_cnt;
  logic [7:0] discard_cnt;
  logic       cfg_legal;

  assign cfg_legal   = CfgWr_i & (CfgDecim_i != 3'd0);
  assign State_o     = state;
  assign FiltNd_o    = DataNd_i & (state != FLUSH);
  assign DataValid_o = FiltValid_i & (state == RUN);

  // Sequencer: flush countdown, discard countdown, factor update on flush entry.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state         <= FLUSH;
      flush_cnt     <= FLUSH_LOAD;
      discard_cnt   <= DISCARD_LOAD;
      FiltRst_o     <= 1'b1;
      DecimFactor_o <= DECIM_RESET;
      CfgBusy_o     <= 1'b1;
      CfgErr_o      <= 1'b0;
    end else begin
      CfgErr_o <= CfgWr_i & (CfgDecim_i == 3'd0);
      case (state)
        FLUSH: begin
          if (cfg_legal) begin
            // A new write restarts the flush; the last write wins.
            DecimFactor_o <= CfgDecim_i;
            flush_cnt     <= FLUSH_LOAD;
          end else if (flush_cnt == 8'd1) begin
            state       <= SETTLE;
            FiltRst_o   <= 1'b0;
            discard_cnt <= DISCARD_LOAD;
          end else begin
            flush_cnt <= flush_cnt - 8'd1;
          end
        end
        SETTLE: begin
          if (cfg_legal) begin
            state         <= FLUSH;
            DecimFactor_o <= CfgDecim_i;
            flush_cnt     <= FLUSH_LOAD;
            FiltRst_o     <= 1'b1;
          end else if (FiltValid_i) begin
            if (discard_cnt == 8'd1) begin
              state     <= RUN;
              CfgBusy_o <= 1'b0;
            end else begin
              discard_cnt <= discard_cnt - 8'd1;
            end
          end
        end
        RUN: begin
          // Rewriting the current factor is a no-op so the filter is not disturbed.
          if (cfg_legal && (CfgDecim_i != DecimFactor_o)) begin
            state         <= FLUSH;
            DecimFactor_o <= CfgDecim_i;
            flush_cnt     <= FLUSH_LOAD;
            FiltRst_o     <= 1'b1;
            CfgBusy_o     <= 1'b1;
          end
        end
        default: begin
          state     <= FLUSH;
          flush_cnt <= FLUSH_LOAD;
          FiltRst_o <= 1'b1;
          CfgBusy_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef CIC_DECIM_CTRL_STATS_EN
  // Saturating count of raw strobes blocked while the filter is held in reset.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      DropCnt_o <= 16'h0000;
    end else if (DataNd_i && (state == FLUSH) && (DropCnt_o != 16'hFFFF)) begin
      DropCnt_o <= DropCnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Testbench for cic_decim_ctrl.
// Directed stimulus, checked in two ways:
//   - a phase-level behavioural model compared on every falling edge;
//   - literal expectations at key points of each scenario.
module tb_cic_decim_ctrl;

  localparam int FLUSH_N   = 8;
  localparam int DISCARD_N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cfg_decim = 3'd0;
  logic       cfg_wr = 1'b0;
  logic       data_nd = 1'b0;
  logic       filt_valid = 1'b0;
  logic       cfg_busy, cfg_err, filt_nd, filt_rst, data_valid;
  logic [2:0] decim_factor;
  logic [1:0] state;
`ifdef CIC_DECIM_CTRL_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cic_decim_ctrl dut (
    .Clk_i        (clk),
    .Rst_i        (rst),
    .CfgDecim_i   (cfg_decim),
    .CfgWr_i      (cfg_wr),
    .CfgBusy_o    (cfg_busy),
    .CfgErr_o     (cfg_err),
    .DataNd_i     (data_nd),
    .FiltNd_o     (filt_nd),
    .FiltRst_o    (filt_rst),
    .DecimFactor_o(decim_factor),
    .FiltValid_i  (filt_valid),
    .DataValid_o  (data_valid),
`ifdef CIC_DECIM_CTRL_STATS_EN
    .State_o      (state),
    .DropCnt_o    (drop_cnt)
`else
    .State_o      (state)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=run, 1=flush, 2=settle; ages count upward.
  int          m_phase;
  int          m_flush_age;
  int          m_discarded;
  int          m_decim;
  bit          m_err;
  int unsigned m_drops;

  always @(posedge clk) begin
    if (rst) begin
      m_phase     <= 1;
      m_flush_age <= 0;
      m_discarded <= 0;
      m_decim     <= 1;
      m_err       <= 1'b0;
      m_drops     <= 0;
    end else begin
      m_err <= cfg_wr && (cfg_decim == 3'd0);
      if (m_phase == 1 && data_nd && m_drops < 65535) m_drops <= m_drops + 1;
      if (m_phase == 1) begin
        if (cfg_wr && cfg_decim != 0) begin
          m_decim <= int'(cfg_decim); m_flush_age <= 0;
        end else if (m_flush_age == FLUSH_N - 1) begin
          m_phase <= 2; m_discarded <= 0;
        end else begin
          m_flush_age <= m_flush_age + 1;
        end
      end else if (m_phase == 2) begin
        if (cfg_wr && cfg_decim != 0) begin
          m_phase <= 1; m_flush_age <= 0; m_decim <= int'(cfg_decim);
        end else if (filt_valid) begin
          if (m_discarded == DISCARD_N - 1) m_phase <= 0;
          else m_discarded <= m_discarded + 1;
        end
      end else begin
        if (cfg_wr && cfg_decim != 0 && int'(cfg_decim) != m_decim) begin
          m_phase <= 1; m_flush_age <= 0; m_decim <= int'(cfg_decim);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_state",    32'(state),        32'(m_phase));
      chk("m_filt_rst", 32'(filt_rst),     32'(m_phase == 1));
      chk("m_busy",     32'(cfg_busy),     32'(m_phase != 0));
      chk("m_decim",    32'(decim_factor), 32'(m_decim));
      chk("m_err",      32'(cfg_err),      32'(m_err));
      chk("m_filt_nd",  32'(filt_nd),      32'(data_nd && m_phase != 1));
      chk("m_valid",    32'(data_valid),   32'(filt_valid && m_phase == 0));
`ifdef CIC_DECIM_CTRL_STATS_EN
      chk("m_drops",    32'(drop_cnt),     32'(m_drops));
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive cycles with FiltRst_o high, starting at the current sample.
  task automatic count_flush(output int n, output int nd_leaks);
    n = 0; nd_leaks = 0;
    while (filt_rst && n < 20) begin
      n++;
      if (filt_nd) nd_leaks++;
      cycle();
    end
  endtask

  // Drives FiltValid_i every cycle until RUN; returns the number of samples consumed.
  task automatic settle_to_run(output int pulses);
    pulses = 0;
    filt_valid = 1'b1;
    while (state != 2'b00 && pulses < 20) begin
      pulses++;
      cycle();
    end
    filt_valid = 1'b0;
    if (pulses >= 20) chk("settle_timeout", 32'(state), 32'd0);
  endtask

  task automatic write_cfg(input logic [2:0] v);
    cfg_wr = 1'b1; cfg_decim = v;
    cycle();
    cfg_wr = 1'b0;
  endtask

  int n, leaks, first_valid, valid_cnt;

  initial begin
    // 1: reset and flush interval after release
    rst = 1'b1; filt_valid = 1'b1;
    cycle();
    chk_en = 1'b1;
    cycle(); cycle();
    chk("rst_filt_rst", 32'(filt_rst), 32'd1);
    chk("rst_decim", 32'(decim_factor), 32'd1);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_state", 32'(state), 32'd1);
    filt_valid = 1'b0; rst = 1'b0;
    count_flush(n, leaks);
    chk("rst_flush_len", 32'(n), 32'd8);
    chk("rst_settle_state", 32'(state), 32'd2);

    // 2: settle with FiltValid_i every second cycle
    first_valid = 0; valid_cnt = 0;
    for (int p = 1; p <= 6; p++) begin
      filt_valid = 1'b1;
      #1;
      if (data_valid) begin
        valid_cnt++;
        if (first_valid == 0) first_valid = p;
      end
      cycle();
      filt_valid = 1'b0;
      if (p == 4) chk("settle_busy_after4", 32'(cfg_busy), 32'd0);
      cycle();
    end
    chk("settle_first_valid", 32'(first_valid), 32'd5);
    chk("settle_valid_cnt", 32'(valid_cnt), 32'd2);
    chk("settle_run_state", 32'(state), 32'd0);

    // 3: factor change to 3 with DataNd_i held high
    data_nd = 1'b1;
    write_cfg(3'd3);
    chk("chg_decim", 32'(decim_factor), 32'd3);
    chk("chg_state", 32'(state), 32'd1);
    count_flush(n, leaks);
    data_nd = 1'b0;
    chk("chg_flush_len", 32'(n), 32'd8);
    chk("chg_nd_leaks", 32'(leaks), 32'd0);
`ifdef CIC_DECIM_CTRL_STATS_EN
    chk("chg_drops", 32'(drop_cnt), 32'd8);
`endif
    settle_to_run(n);
    chk("chg_discards", 32'(n), 32'd4);

    // 4: rewrite of the current factor is ignored
    write_cfg(3'd3);
    chk("same_state", 32'(state), 32'd0);
    chk("same_busy", 32'(cfg_busy), 32'd0);

    // 5: illegal zero factor
    write_cfg(3'd0);
    chk("err_pulse", 32'(cfg_err), 32'd1);
    chk("err_decim", 32'(decim_factor), 32'd3);
    chk("err_state", 32'(state), 32'd0);
    cycle();
    chk("err_pulse_end", 32'(cfg_err), 32'd0);

    // Write and valid sample in the same RUN cycle: sample passes, then flush
    cfg_wr = 1'b1; cfg_decim = 3'd2; filt_valid = 1'b1;
    #1;
    chk("wr_valid_pass", 32'(data_valid), 32'd1);
    cycle();
    cfg_wr = 1'b0; filt_valid = 1'b0;
    chk("wr_valid_flush", 32'(state), 32'd1);
    count_flush(n, leaks);
    settle_to_run(n);

    // 6: rewrite during SETTLE restarts the flush and the discard count
    write_cfg(3'd6);
    count_flush(n, leaks);
    for (int p = 0; p < 2; p++) begin
      filt_valid = 1'b1; cycle();
      filt_valid = 1'b0; cycle();
    end
    chk("restart_pre_state", 32'(state), 32'd2);
    data_nd = 1'b1;
    write_cfg(3'd5);
    chk("restart_decim", 32'(decim_factor), 32'd5);
    chk("restart_state", 32'(state), 32'd1);
    count_flush(n, leaks);
    data_nd = 1'b0;
    chk("restart_flush_len", 32'(n), 32'd8);
`ifdef CIC_DECIM_CTRL_STATS_EN
    chk("restart_drops", 32'(drop_cnt), 32'd16);
`endif
    settle_to_run(n);
    chk("restart_discards", 32'(n), 32'd4);

    // Reset mid-flush drops the pending factor
    write_cfg(3'd7);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_decim", 32'(decim_factor), 32'd1);
    chk("midrst_state", 32'(state), 32'd1);
    cycle(); cycle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
